// File: rtl/m_net_req_arb_nch.sv
// N-channel M_NET request arbiter: latches board requests, grants round-robin,
// streams a fixed-length frame from the granted board's buffer and routes tx data back.
module m_net_req_arb_nch #(
  parameter int CH_NUM    = 4,
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter int FRAME_LEN = 156,
  parameter int TIMEOUT   = 1500,
  parameter int DONE_DLY  = 5
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic [CH_NUM-1:0]           im_req,
  input  logic [2:0]                  im_mode_reg,
  output logic [CH_NUM*AW-1:0]        om_rd_addr,
  input  logic [CH_NUM*DW-1:0]        im_rd_data,
  output logic                        o_rx_start,
  output logic [DW-1:0]               om_rx_data,
  output logic                        o_rx_data_en,
  output logic                        o_rx_end,
  output logic [$clog2(CH_NUM)-1:0]   om_rx_ch,
  input  logic [DW-1:0]               im_tx_data,
  input  logic                        i_tx_data_en,
  input  logic                        i_tx_busy,
  output logic [CH_NUM-1:0]           om_tx_data_en,
  output logic [CH_NUM*DW-1:0]        om_tx_data,
  output logic                        o_timeout
);

  localparam int          CW          = $clog2(CH_NUM);
  localparam logic [15:0] FRAME_LEN_C = 16'(FRAME_LEN);
  localparam logic [15:0] TIMEOUT_C   = 16'(TIMEOUT);

  typedef enum logic {IDLE, SERVE} state_e;

  state_e                state_q;
  logic [CH_NUM-1:0]     pending_q, pending_d;
  logic [CW-1:0]         grant_q, lastGrant_q, arbCh, arbCand;
  logic                  arbFound;
  logic [15:0]           cnt_q;
  logic                  rdEn, rdEnD1_q, rxEn_q, rxEnd_q, timeout_q;
  logic [DW-1:0]         rxData_q;
  logic                  busyD_q, busyFall, txDone;
  logic [DONE_DLY-1:0]   doneSr_q;
  logic [CH_NUM-1:0]     txSel, txEn_q;
  logic [CH_NUM*DW-1:0]  txData_q;

  // First pending channel after the last grant, wrapping around.
  always_comb begin
    arbFound = 1'b0;
    arbCh    = '0;
    arbCand  = '0;
    for (int k = 1; k <= CH_NUM; k++) begin
      arbCand = CW'((int'(lastGrant_q) + k) % CH_NUM);
      if (!arbFound && pending_q[arbCand]) begin
        arbFound = 1'b1;
        arbCh    = arbCand;
      end
    end
  end

  // A request arriving in the same cycle as the service clear is kept.
  always_comb begin
    pending_d = pending_q | im_req;
    if (state_q == SERVE) pending_d[grant_q] = im_req[grant_q];
  end

  assign rdEn     = (state_q == SERVE) && (cnt_q < FRAME_LEN_C);
  assign busyFall = busyD_q & ~i_tx_busy;
  assign txDone   = doneSr_q[DONE_DLY-1];

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      lastGrant_q <= CW'(CH_NUM - 1);
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arbFound) begin
            state_q     <= SERVE;
            grant_q     <= arbCh;
            lastGrant_q <= arbCh;
            cnt_q       <= '0;
          end
        end
        SERVE: begin
          if (txDone) begin
            cnt_q <= '0;
            if (arbFound) begin
              grant_q     <= arbCh;
              lastGrant_q <= arbCh;
            end else begin
              state_q <= IDLE;
            end
          end else if (cnt_q == TIMEOUT_C) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data arrives one cycle after the address and is registered once more.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      rdEnD1_q  <= 1'b0;
      rxEn_q    <= 1'b0;
      rxEnd_q   <= 1'b0;
      rxData_q  <= '0;
      busyD_q   <= 1'b0;
      doneSr_q  <= '0;
    end else begin
      pending_q <= pending_d;
      rdEnD1_q  <= rdEn;
      rxEn_q    <= rdEnD1_q;
      rxEnd_q   <= rxEn_q & ~rdEnD1_q;
      rxData_q  <= rdEnD1_q ? im_rd_data[grant_q*DW +: DW] : '0;
      busyD_q   <= i_tx_busy;
      doneSr_q  <= (doneSr_q << 1) | DONE_DLY'(busyFall);
    end
  end

  always_comb begin
    om_rd_addr = '0;
    if (rdEn) om_rd_addr[grant_q*AW +: AW] = cnt_q[AW-1:0];
  end

  always_comb begin
    txSel = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      txSel[i] = (im_mode_reg == 3'b010) || ((state_q == SERVE) && (grant_q == CW'(i)));
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      txEn_q   <= '0;
      txData_q <= '0;
    end else begin
      txEn_q <= txSel & {CH_NUM{i_tx_data_en}};
      for (int i = 0; i < CH_NUM; i++) begin
        txData_q[i*DW +: DW] <= txSel[i] ? im_tx_data : '0;
      end
    end
  end

  assign o_rx_start    = rdEn & ~rdEnD1_q;
  assign om_rx_data    = rxData_q;
  assign o_rx_data_en  = rxEn_q;
  assign o_rx_end      = rxEnd_q;
  assign om_rx_ch      = grant_q;
  assign om_tx_data_en = txEn_q;
  assign om_tx_data    = txData_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_m_net_req_arb_nch.sv
// Directed bench for m_net_req_arb_nch: single frame, round-robin order, fairness,
// watchdog, tx routing and asynchronous reset in the middle of a frame.
module tb_m_net_req_arb_nch;

  localparam int CH_NUM    = 4;
  localparam int DW        = 8;
  localparam int AW        = 8;
  localparam int FRAME_LEN = 156;
  localparam int TIMEOUT   = 1500;
  localparam int DONE_DLY  = 5;

  logic                      sys_clk = 1'b0;
  logic                      rst;
  logic [CH_NUM-1:0]         im_req;
  logic [2:0]                im_mode_reg;
  logic [CH_NUM*AW-1:0]      om_rd_addr;
  logic [CH_NUM*DW-1:0]      im_rd_data;
  logic                      o_rx_start;
  logic [DW-1:0]             om_rx_data;
  logic                      o_rx_data_en;
  logic                      o_rx_end;
  logic [1:0]                om_rx_ch;
  logic [DW-1:0]             im_tx_data;
  logic                      i_tx_data_en;
  logic                      i_tx_busy;
  logic [CH_NUM-1:0]         om_tx_data_en;
  logic [CH_NUM*DW-1:0]      om_tx_data;
  logic                      o_timeout;

  int checksTotal  = 0;
  int checksPassed = 0;

  logic       expEn;
  logic [7:0] expData;
  logic [63:0] expAddr;

  m_net_req_arb_nch #(
    .CH_NUM(CH_NUM), .DW(DW), .AW(AW), .FRAME_LEN(FRAME_LEN),
    .TIMEOUT(TIMEOUT), .DONE_DLY(DONE_DLY)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .im_req(im_req), .im_mode_reg(im_mode_reg),
    .om_rd_addr(om_rd_addr), .im_rd_data(im_rd_data), .o_rx_start(o_rx_start),
    .om_rx_data(om_rx_data), .o_rx_data_en(o_rx_data_en), .o_rx_end(o_rx_end),
    .om_rx_ch(om_rx_ch), .im_tx_data(im_tx_data), .i_tx_data_en(i_tx_data_en),
    .i_tx_busy(i_tx_busy), .om_tx_data_en(om_tx_data_en), .om_tx_data(om_tx_data),
    .o_timeout(o_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  // Per-board receive buffers: fixed content pattern with one cycle of read latency.
  function automatic logic [7:0] memWord(input int ch, input int a);
    return 8'((a * 7 + ch * 61 + 3) % 256);
  endfunction

  always @(posedge sys_clk) begin
    for (int c = 0; c < CH_NUM; c++) begin
      im_rd_data[c*DW +: DW] <= memWord(c, int'(om_rd_addr[c*AW +: AW]));
    end
  end

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checksTotal++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Drives every stimulus input at once.
  task automatic applyStimulus(input logic [3:0] req, input logic busy, input logic [2:0] mode,
                               input logic [7:0] txd, input logic txen);
    im_req       = req;
    i_tx_busy    = busy;
    im_mode_reg  = mode;
    im_tx_data   = txd;
    i_tx_data_en = txen;
  endtask

  // Ends the current grant with a busy 1->0 edge and checks the hand-over timing.
  task automatic serveEnd(input string tag, input int oldCh, input int newCh,
                          input logic expStart, input logic [3:0] holdReq);
    applyStimulus(holdReq, 1'b1, 3'b001, 8'h00, 1'b0);
    @(negedge sys_clk);
    applyStimulus(holdReq, 1'b0, 3'b001, 8'h00, 1'b0);
    repeat (DONE_DLY) @(negedge sys_clk);
    checkOutput({tag, " hold"}, 64'(om_rx_ch), 64'(oldCh));
    @(negedge sys_clk);
    applyStimulus(4'b0000, 1'b0, 3'b001, 8'h00, 1'b0);
    if (newCh >= 0) begin
      checkOutput({tag, " grant"}, 64'(om_rx_ch), 64'(newCh));
      checkOutput({tag, " addr0"}, 64'(om_rd_addr), 64'd0);
      checkOutput({tag, " start"}, 64'(o_rx_start), 64'(expStart));
      @(negedge sys_clk);
      checkOutput({tag, " addr1"}, 64'(om_rd_addr), 64'd1 << (newCh * AW));
    end else begin
      applyStimulus(4'b0000, 1'b0, 3'b001, 8'h00, 1'b1);
      @(negedge sys_clk);
      checkOutput({tag, " idle tx"}, 64'(om_tx_data_en), 64'd0);
      applyStimulus(4'b0000, 1'b0, 3'b001, 8'h00, 1'b0);
    end
  endtask

  // Hard stop in case something upstream never returns.
  initial begin
    #(100000 * 10);
    $display("[TB] FAIL global timeout: observed no finish, expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(4'b0000, 1'b0, 3'b001, 8'h00, 1'b0);
    repeat (2) @(negedge sys_clk);

    // Reset state
    checkOutput("rst addr",    64'(om_rd_addr),    64'd0);
    checkOutput("rst start",   64'(o_rx_start),    64'd0);
    checkOutput("rst rxen",    64'(o_rx_data_en),  64'd0);
    checkOutput("rst rxdata",  64'(om_rx_data),    64'd0);
    checkOutput("rst rxend",   64'(o_rx_end),      64'd0);
    checkOutput("rst ch",      64'(om_rx_ch),      64'd0);
    checkOutput("rst txen",    64'(om_tx_data_en), 64'd0);
    checkOutput("rst txdata",  64'(om_tx_data),    64'd0);
    checkOutput("rst timeout", 64'(o_timeout),     64'd0);
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Single request on ch2: full frame walk, cycle by cycle from the grant
    applyStimulus(4'b0100, 1'b0, 3'b001, 8'h00, 1'b0);
    @(negedge sys_clk);
    applyStimulus(4'b0000, 1'b0, 3'b001, 8'h00, 1'b0);
    checkOutput("t1 pre start", 64'(o_rx_start), 64'd0);
    @(negedge sys_clk);
    for (int k = 0; k <= FRAME_LEN + 4; k++) begin
      expAddr = (k < FRAME_LEN) ? (64'(k) << (2 * AW)) : 64'd0;
      expEn   = (k >= 2) && (k < FRAME_LEN + 2);
      expData = expEn ? memWord(2, k - 2) : 8'h00;
      checkOutput($sformatf("t1 addr k%0d", k),  64'(om_rd_addr),   expAddr);
      checkOutput($sformatf("t1 rxen k%0d", k),  64'(o_rx_data_en), 64'(expEn));
      checkOutput($sformatf("t1 data k%0d", k),  64'(om_rx_data),   64'(expData));
      checkOutput($sformatf("t1 start k%0d", k), 64'(o_rx_start),   64'(k == 0));
      checkOutput($sformatf("t1 end k%0d", k),   64'(o_rx_end),     64'(k == FRAME_LEN + 2));
      checkOutput($sformatf("t1 ch k%0d", k),    64'(om_rx_ch),     64'd2);
      @(negedge sys_clk);
    end
    serveEnd("t1 release", 2, -1, 1'b0, 4'b0000);

    // Construction-mode broadcast while idle, then back to run mode
    applyStimulus(4'b0000, 1'b0, 3'b010, 8'hA5, 1'b1);
    checkOutput("t5 bcast latency", 64'(om_tx_data_en), 64'd0);
    @(negedge sys_clk);
    checkOutput("t5 bcast en",   64'(om_tx_data_en), 64'hF);
    checkOutput("t5 bcast data", 64'(om_tx_data),    64'hA5A5_A5A5);
    applyStimulus(4'b0000, 1'b0, 3'b001, 8'hA5, 1'b1);
    @(negedge sys_clk);
    checkOutput("t5 run idle en",   64'(om_tx_data_en), 64'd0);
    checkOutput("t5 run idle data", 64'(om_tx_data),    64'd0);
    applyStimulus(4'b0000, 1'b0, 3'b001, 8'h00, 1'b0);

    // Asynchronous reset at cnt=80 of a ch1 grant
    applyStimulus(4'b0010, 1'b0, 3'b001, 8'h5A, 1'b1);
    @(negedge sys_clk);
    applyStimulus(4'b0000, 1'b0, 3'b001, 8'h5A, 1'b1);
    @(negedge sys_clk);
    checkOutput("t6 grant", 64'(om_rx_ch), 64'd1);
    repeat (80) @(negedge sys_clk);
    checkOutput("t6 addr80", 64'(om_rd_addr),    64'd80 << AW);
    checkOutput("t6 txen",   64'(om_tx_data_en), 64'b0010);
    checkOutput("t6 txdata", 64'(om_tx_data),    64'h5A << DW);
    rst = 1'b1;
    #1;
    checkOutput("t6 rst addr",   64'(om_rd_addr),    64'd0);
    checkOutput("t6 rst rxen",   64'(o_rx_data_en),  64'd0);
    checkOutput("t6 rst rxdata", 64'(om_rx_data),    64'd0);
    checkOutput("t6 rst ch",     64'(om_rx_ch),      64'd0);
    checkOutput("t6 rst txen",   64'(om_tx_data_en), 64'd0);
    checkOutput("t6 rst txdata", 64'(om_tx_data),    64'd0);
    @(negedge sys_clk);
    applyStimulus(4'b0000, 1'b0, 3'b001, 8'h00, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    checkOutput("t6 idle start", 64'(o_rx_start), 64'd0);
    checkOutput("t6 idle addr",  64'(om_rd_addr), 64'd0);

    // Round-robin: all four at once, order must be 0,1,2,3
    applyStimulus(4'b1111, 1'b0, 3'b001, 8'h00, 1'b0);
    @(negedge sys_clk);
    applyStimulus(4'b0000, 1'b0, 3'b001, 8'h00, 1'b0);
    @(negedge sys_clk);
    checkOutput("t2 first ch",    64'(om_rx_ch),   64'd0);
    checkOutput("t2 first start", 64'(o_rx_start), 64'd1);
    for (int g = 0; g < CH_NUM; g++) begin
      repeat (FRAME_LEN + 8) @(negedge sys_clk);
      serveEnd($sformatf("t2 rr%0d", g), g, (g < CH_NUM - 1) ? g + 1 : -1, 1'b1, 4'b0000);
    end

    // Fairness: ch1 re-requests during its own service while ch3 waits
    applyStimulus(4'b1010, 1'b0, 3'b001, 8'h00, 1'b0);
    @(negedge sys_clk);
    applyStimulus(4'b0000, 1'b0, 3'b001, 8'h00, 1'b0);
    @(negedge sys_clk);
    checkOutput("t3 first ch", 64'(om_rx_ch), 64'd1);
    repeat (FRAME_LEN + 8) @(negedge sys_clk);
    serveEnd("t3 to ch3", 1, 3, 1'b1, 4'b0010);
    repeat (FRAME_LEN + 8) @(negedge sys_clk);
    serveEnd("t3 back ch1", 3, 1, 1'b1, 4'b0000);
    repeat (FRAME_LEN + 8) @(negedge sys_clk);
    serveEnd("t3 release", 1, -1, 1'b0, 4'b0000);

    // Watchdog: ch0 with busy held high
    applyStimulus(4'b0001, 1'b1, 3'b001, 8'h00, 1'b0);
    @(negedge sys_clk);
    applyStimulus(4'b0000, 1'b1, 3'b001, 8'h00, 1'b0);
    @(negedge sys_clk);
    checkOutput("t4 grant", 64'(om_rx_ch),   64'd0);
    checkOutput("t4 start", 64'(o_rx_start), 64'd1);
    repeat (TIMEOUT) @(negedge sys_clk);
    checkOutput("t4 before timeout", 64'(o_timeout), 64'd0);
    @(negedge sys_clk);
    checkOutput("t4 timeout pulse", 64'(o_timeout), 64'd1);
    @(negedge sys_clk);
    checkOutput("t4 timeout drop", 64'(o_timeout),  64'd0);
    checkOutput("t4 no regrant",   64'(o_rx_start), 64'd0);
    checkOutput("t4 idle addr",    64'(om_rd_addr), 64'd0);
    @(negedge sys_clk);
    checkOutput("t4 no regrant 2", 64'(o_rx_start), 64'd0);
    applyStimulus(4'b0000, 1'b0, 3'b001, 8'h00, 1'b0);
    repeat (DONE_DLY + 3) @(negedge sys_clk);
    checkOutput("t4 stays idle", 64'(om_rd_addr), 64'd0);

    // Run-mode routing with ch3 granted; undefined and download modes behave as run
    applyStimulus(4'b1000, 1'b0, 3'b001, 8'h3C, 1'b1);
    @(negedge sys_clk);
    applyStimulus(4'b0000, 1'b0, 3'b001, 8'h3C, 1'b1);
    @(negedge sys_clk);
    checkOutput("t5 ch3 grant",   64'(om_rx_ch),      64'd3);
    checkOutput("t5 ch3 latency", 64'(om_tx_data_en), 64'd0);
    @(negedge sys_clk);
    checkOutput("t5 ch3 en",   64'(om_tx_data_en), 64'b1000);
    checkOutput("t5 ch3 data", 64'(om_tx_data),    64'h3C00_0000);
    applyStimulus(4'b0000, 1'b0, 3'b111, 8'h77, 1'b1);
    @(negedge sys_clk);
    checkOutput("t5 mode111 en",   64'(om_tx_data_en), 64'b1000);
    checkOutput("t5 mode111 data", 64'(om_tx_data),    64'h7700_0000);
    applyStimulus(4'b0000, 1'b0, 3'b100, 8'h11, 1'b0);
    @(negedge sys_clk);
    checkOutput("t5 mode100 en",   64'(om_tx_data_en), 64'd0);
    checkOutput("t5 mode100 data", 64'(om_tx_data),    64'h1100_0000);
    serveEnd("t5 release", 3, -1, 1'b0, 4'b0000);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/m_net_req_arb_nch.md
Name: m_net_req_arb_nch

Overview:
N-channel successor to the two-board M_NET request controller. It latches per-board send requests and grants one board at a time using round-robin arbitration. For the granted board it reads a fixed-length frame out of that board's receive buffer and streams it to the protocol layer. It routes transmit data back to the granted board, or to all boards in construction mode, and it bounds each grant with a done-detector and a timeout.

Parameters:
CH_NUM, 4, number of boards/channels (2..8)
DW, 8, data width per channel
AW, 8, read-address width per channel buffer
FRAME_LEN, 156, words read per grant (1..2^AW)
TIMEOUT, 1500, grant watchdog in sys_clk cycles (must exceed FRAME_LEN+2)
DONE_DLY, 5, cycles from tx-busy falling edge to grant release (>=1)

Ports:
sys_clk  in  1  system clock, 50 MHz
rst  in  1  reset, asynchronous, active-high
im_req  in  CH_NUM  per-channel request-to-send pulse/level
im_mode_reg  in  3  001 run, 010 construction (tx broadcast), 100 download
om_rd_addr  out  CH_NUM*AW  per-channel buffer read address, channel i at [i*AW +: AW]
im_rd_data  in  CH_NUM*DW  per-channel buffer read data, 1-cycle read latency
o_rx_start  out  1  pulse: frame read begins
om_rx_data  out  DW  frame data to protocol layer
o_rx_data_en  out  1  frame data valid
o_rx_end  out  1  pulse: cycle after last valid word
om_rx_ch  out  clog2(CH_NUM)  index of currently granted channel
im_tx_data  in  DW  transmit data
i_tx_data_en  in  1  transmit data valid
i_tx_busy  in  1  transmitter busy
om_tx_data_en  out  CH_NUM  per-channel tx enable
om_tx_data  out  CH_NUM*DW  per-channel tx data
o_timeout  out  1  pulse: grant aborted by watchdog

Behaviour:
- Reset (rst=1, async): every output 0; FSM IDLE; all pending latches 0; counter 0; last-grant pointer CH_NUM-1, so ch0 has first priority after reset.
- Pending latch per channel: set when im_req[i]=1. Cleared in any cycle the FSM is in SERVE with grant==i. If set and clear coincide, set wins: a re-request during service is kept and served later.
- Arbitration: the grant goes to the first pending channel scanning last_grant+1 upward, wrapping modulo CH_NUM. last_grant updates on each new grant.
- FSM:
  - IDLE -> SERVE when any pending.
  - SERVE -> SERVE with a new grant on tx_done when another channel is pending. The counter clears and a new frame starts the next cycle.
  - SERVE -> IDLE on tx_done with nothing pending.
  - SERVE -> IDLE when cnt==TIMEOUT. o_timeout pulses 1 cycle and the latch of the aborted channel stays clear.
  - tx_done and timeout in the same cycle: tx_done wins and there is no o_timeout.
- cnt: 16-bit, 0 on entry to each grant, +1 per cycle in SERVE. It cannot wrap because the watchdog exits at TIMEOUT.
- Read side:
  - rd_en = SERVE && cnt<FRAME_LEN.
  - Granted channel's om_rd_addr = cnt[AW-1:0] while rd_en, else 0. Non-granted channels are held at 0.
  - o_rx_data_en = rd_en delayed 2 cycles.
  - om_rx_data = granted channel's im_rd_data, registered once, aligned with o_rx_data_en. It is 0 when not valid.
  - Exactly FRAME_LEN consecutive valid words per grant, addresses 0..FRAME_LEN-1 in order.
- o_rx_start pulses on the rising edge of rd_en, 2 cycles before the first valid word.
- o_rx_end pulses the cycle after o_rx_data_en falls.
- A grant aborted mid-read truncates the frame; o_rx_end still fires.
- tx_done = (i_tx_busy falling edge) delayed DONE_DLY cycles through a shift register.
- Tx routing (registered, 1-cycle latency):
  - im_mode_reg==010: every channel gets im_tx_data/i_tx_data_en.
  - Otherwise in SERVE: only the granted channel gets them.
  - All other channels, and all channels in IDLE, drive 0.
- Undefined im_mode_reg values are treated as run mode.

Test Plan:
- Single request: pulse im_req[2], CH_NUM=4 -> o_rx_start 1 cycle after grant; om_rd_addr ch2 counts 0..155; o_rx_data_en high 156 cycles starting 2 cycles after rd_en rise; o_rx_end 1 cycle after the last word; om_rx_ch=2.
- Round-robin: all four im_req asserted simultaneously after reset, each grant ended by an i_tx_busy 1->0 -> grant order 0,1,2,3. Each hand-over occurs exactly 5 cycles after the busy falling edge.
- Fairness: ch1 re-requests during its own service while ch3 is pending -> ch3 is served before ch1's second grant.
- Watchdog: grant ch0 and hold i_tx_busy=1 -> return to IDLE at cnt=1500; o_timeout is a 1-cycle pulse; ch0 latch is 0.
- Tx routing: im_mode_reg=010, stream 0xA5 with en=1 -> all om_tx_data lanes = 0xA5 one cycle later. With im_mode_reg=001 and ch3 granted, only lane 3 is active and the others are 0.
- Reset mid-frame: assert rst at cnt=80 -> all outputs 0 immediately. After release the FSM sits in IDLE and ch0 has priority.
